// File: rtl/bsg_cache_amo_exec.sv
// Word-granular AMO_W read-modify-write sequencer between cache decode and the data-memory arbiter.
// Optional macro BSG_CACHE_AMO_SKIP_WRITE_EN: skip the write-back when the new value equals the old one.

package bsg_cache_amo_exec_pkg;

    typedef struct packed {
        logic [1:0] size_op;
        logic       sigext_op;
        logic       ld_op;
        logic       st_op;
        logic       atomic_op;
        logic       amoswap_op;
        logic       amoadd_op;
        logic       amoxor_op;
        logic       amoand_op;
        logic       amoor_op;
        logic       amomin_op;
        logic       amomax_op;
        logic       amominu_op;
        logic       amomaxu_op;
    } bsg_cache_decode_s;

    typedef struct packed {
        logic swap_op;
        logic add_op;
        logic xor_op;
        logic and_op;
        logic or_op;
        logic min_op;
        logic max_op;
        logic minu_op;
        logic maxu_op;
    } amo_op_s;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_RESP
    } amo_state_e;

endpackage

module bsg_cache_amo_exec
    import bsg_cache_amo_exec_pkg::*;
#(
    parameter int unsigned addr_width_p = 32,
    parameter int unsigned data_width_p = 32
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          v_i,
    input  bsg_cache_decode_s             decode_i,
    input  logic [addr_width_p-1:0]       addr_i,
    input  logic [data_width_p-1:0]       data_i,
    output logic                          ready_o,
    output logic                          mem_v_o,
    output logic                          mem_w_o,
    output logic [addr_width_p-1:0]       mem_addr_o,
    output logic [data_width_p-1:0]       mem_data_o,
    output logic [(data_width_p/8)-1:0]   mem_mask_o,
    input  logic                          mem_yumi_i,
    input  logic                          mem_data_v_i,
    input  logic [data_width_p-1:0]       mem_data_i,
    output logic                          v_o,
    output logic [data_width_p-1:0]       data_o,
    input  logic                          yumi_i
);

    localparam int unsigned mask_width_lp = data_width_p / 8;

    if (data_width_p != 32) begin : g_width_check
        $error("bsg_cache_amo_exec: data_width_p must be 32");
    end

    amo_state_e              state_r, state_n;
    amo_op_s                 op_r, op_in;
    logic [data_width_p-1:0] operand_r;
    logic [data_width_p-1:0] amo_result;
    logic                    accept, capture, skip_write;

    // Fields of the decode bundle this block never looks at.
    logic unused_inputs;
    assign unused_inputs = ^{decode_i.size_op, decode_i.sigext_op, decode_i.ld_op,
                             decode_i.st_op, addr_i[1:0]};

    assign op_in = '{
        swap_op: decode_i.amoswap_op,
        add_op:  decode_i.amoadd_op,
        xor_op:  decode_i.amoxor_op,
        and_op:  decode_i.amoand_op,
        or_op:   decode_i.amoor_op,
        min_op:  decode_i.amomin_op,
        max_op:  decode_i.amomax_op,
        minu_op: decode_i.amominu_op,
        maxu_op: decode_i.amomaxu_op
    };

    // New value from the returning memory word; ties in min/max keep the old word.
    always_comb begin
        amo_result = mem_data_i;
        if (op_r.swap_op)
            amo_result = operand_r;
        else if (op_r.add_op)
            amo_result = data_width_p'(mem_data_i + operand_r);
        else if (op_r.xor_op)
            amo_result = mem_data_i ^ operand_r;
        else if (op_r.and_op)
            amo_result = mem_data_i & operand_r;
        else if (op_r.or_op)
            amo_result = mem_data_i | operand_r;
        else if (op_r.min_op)
            amo_result = ($signed(operand_r) < $signed(mem_data_i)) ? operand_r : mem_data_i;
        else if (op_r.max_op)
            amo_result = ($signed(operand_r) > $signed(mem_data_i)) ? operand_r : mem_data_i;
        else if (op_r.minu_op)
            amo_result = (operand_r < mem_data_i) ? operand_r : mem_data_i;
        else if (op_r.maxu_op)
            amo_result = (operand_r > mem_data_i) ? operand_r : mem_data_i;
    end

`ifdef BSG_CACHE_AMO_SKIP_WRITE_EN
    assign skip_write = (amo_result == mem_data_i);
`else
    assign skip_write = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state_r <= S_IDLE;
        else
            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_r)
            S_IDLE: begin
                accept = v_i & decode_i.atomic_op;
                if (accept)
                    state_n = S_RD_REQ;
            end
            S_RD_REQ: begin
                if (mem_yumi_i)
                    state_n = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                capture = mem_data_v_i;
                if (mem_data_v_i)
                    state_n = skip_write ? S_RESP : S_WR_REQ;
            end
            S_WR_REQ: begin
                if (mem_yumi_i)
                    state_n = S_RESP;
            end
            S_RESP: begin
                if (yumi_i)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ready_o    <= 1'b1;
            mem_v_o    <= 1'b0;
            mem_w_o    <= 1'b0;
            mem_mask_o <= '0;
            v_o        <= 1'b0;
        end else begin
            ready_o    <= (state_n == S_IDLE);
            mem_v_o    <= (state_n == S_RD_REQ) || (state_n == S_WR_REQ);
            mem_w_o    <= (state_n == S_WR_REQ);
            mem_mask_o <= {mask_width_lp{state_n == S_WR_REQ}};
            v_o        <= (state_n == S_RESP);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_addr_o <= '0;
            operand_r  <= '0;
            op_r       <= '0;
            mem_data_o <= '0;
            data_o     <= '0;
        end else begin
            if (accept) begin
                mem_addr_o <= {addr_i[addr_width_p-1:2], 2'b00};
                operand_r  <= data_i;
                op_r       <= op_in;
            end
            if (capture) begin
                data_o     <= mem_data_i;
                mem_data_o <= amo_result;
            end
        end
    end

endmodule

// File: tb/tb_bsg_cache_amo_exec.sv
// Directed bench for bsg_cache_amo_exec with a reactive data-memory responder.
// Expectations follow BSG_CACHE_AMO_SKIP_WRITE_EN when it is defined for the build.

module tb_bsg_cache_amo_exec;
    import bsg_cache_amo_exec_pkg::*;

`ifdef BSG_CACHE_AMO_SKIP_WRITE_EN
    localparam bit skip_en = 1'b1;
`else
    localparam bit skip_en = 1'b0;
`endif

    localparam int OP_SWAP = 0, OP_ADD = 1, OP_XOR = 2, OP_AND = 3, OP_OR = 4;
    localparam int OP_MIN = 5, OP_MAX = 6, OP_MINU = 7, OP_MAXU = 8;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              v_i;
    bsg_cache_decode_s decode_i;
    logic [31:0]       addr_i, data_i;
    logic              ready_o, mem_v_o, mem_w_o;
    logic [31:0]       mem_addr_o, mem_data_o;
    logic [3:0]        mem_mask_o;
    logic              mem_yumi_i, mem_data_v_i;
    logic [31:0]       mem_data_i;
    logic              v_o;
    logic [31:0]       data_o;
    logic              yumi_i;

    int n_checks = 0;
    int n_pass   = 0;

    bsg_cache_amo_exec dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .decode_i     (decode_i),
        .addr_i       (addr_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .mem_v_o      (mem_v_o),
        .mem_w_o      (mem_w_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_mask_o   (mem_mask_o),
        .mem_yumi_i   (mem_yumi_i),
        .mem_data_v_i (mem_data_v_i),
        .mem_data_i   (mem_data_i),
        .v_o          (v_o),
        .data_o       (data_o),
        .yumi_i       (yumi_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic bsg_cache_decode_s mk_amo(input int k);
        bsg_cache_decode_s d;
        d = '0;
        d.atomic_op = 1'b1;
        case (k)
            OP_SWAP: d.amoswap_op = 1'b1;
            OP_ADD:  d.amoadd_op  = 1'b1;
            OP_XOR:  d.amoxor_op  = 1'b1;
            OP_AND:  d.amoand_op  = 1'b1;
            OP_OR:   d.amoor_op   = 1'b1;
            OP_MIN:  d.amomin_op  = 1'b1;
            OP_MAX:  d.amomax_op  = 1'b1;
            OP_MINU: d.amominu_op = 1'b1;
            default: d.amomaxu_op = 1'b1;
        endcase
        return d;
    endfunction

    // Issue one AMO and play the memory side with the given stall counts.
    task automatic run_amo(input string tag, input int k, input logic [31:0] addr,
                           input logic [31:0] opnd, input logic [31:0] memv,
                           input int rd_stall, input int wr_stall, input int rs_stall,
                           input bit exp_wr, input logic [31:0] exp_new, input int exp_lat);
        logic [31:0] exp_addr;
        int  rd_n = 0, wr_n = 0, rs_n = 0, lat = -1;
        bit  data_next = 1'b0, saw_wr = 1'b0, done = 1'b0;
        exp_addr = addr & ~32'h3;
        @(negedge clk);
        check({tag, "_ready_idle"}, 32'(ready_o), 32'd1);
        v_i = 1'b1; decode_i = mk_amo(k); addr_i = addr; data_i = opnd;
        for (int cyc = 1; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            v_i = 1'b0; decode_i = '0; addr_i = '0; data_i = '0;
            mem_yumi_i = 1'b0; mem_data_v_i = 1'b0; mem_data_i = 32'hDEAD_BEEF; yumi_i = 1'b0;
            check({tag, "_ready_busy"}, 32'(ready_o), 32'd0);
            if (data_next) begin
                mem_data_v_i = 1'b1; mem_data_i = memv; data_next = 1'b0;
            end
            if (mem_v_o) begin
                check({tag, "_addr"}, mem_addr_o, exp_addr);
                if (!mem_w_o) begin
                    check({tag, "_rd_mask"}, 32'(mem_mask_o), 32'h0);
                    if (rd_n == rd_stall) begin mem_yumi_i = 1'b1; data_next = 1'b1; end
                    else rd_n++;
                end else begin
                    saw_wr = 1'b1;
                    check({tag, "_wr_data"}, mem_data_o, exp_new);
                    check({tag, "_wr_mask"}, 32'(mem_mask_o), 32'hF);
                    if (wr_n == wr_stall) mem_yumi_i = 1'b1;
                    else wr_n++;
                end
            end
            if (v_o) begin
                if (lat < 0) lat = cyc;
                check({tag, "_data_o"}, data_o, memv);
                if (rs_n == rs_stall) begin yumi_i = 1'b1; done = 1'b1; end
                else rs_n++;
            end
        end
        check({tag, "_no_timeout"}, 32'(done), 32'd1);
        @(negedge clk);
        mem_yumi_i = 1'b0; mem_data_v_i = 1'b0; yumi_i = 1'b0;
        check({tag, "_ready_after"}, 32'(ready_o), 32'd1);
        check({tag, "_v_o_after"}, 32'(v_o), 32'd0);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_wrote"}, 32'(saw_wr), 32'(exp_wr));
    endtask

    initial begin
        reset_i = 1'b1; v_i = 1'b0; decode_i = '0; addr_i = '0; data_i = '0;
        mem_yumi_i = 1'b0; mem_data_v_i = 1'b0; mem_data_i = '0; yumi_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_mem_v", 32'(mem_v_o), 32'd0);
        check("rst_mem_w", 32'(mem_w_o), 32'd0);
        check("rst_mask", 32'(mem_mask_o), 32'd0);
        check("rst_v_o", 32'(v_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_data_o, 32'd0);
        check("rst_data_o", data_o, 32'd0);

        run_amo("add_wrap", OP_ADD, 32'h10, 32'd1, 32'h7FFF_FFFF, 0, 0, 0, 1'b1, 32'h8000_0000, 4);
        run_amo("min_s", OP_MIN, 32'h20, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, !skip_en, 32'hFFFF_FFFF, skip_en ? 3 : 4);
        run_amo("min_u", OP_MINU, 32'h24, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 1'b1, 32'h0000_0001, 4);
        run_amo("swap_bp", OP_SWAP, 32'h2A, 32'h0000_CAFE, 32'h0000_1234, 3, 3, 2, 1'b1, 32'h0000_CAFE, 10);
        run_amo("xor", OP_XOR, 32'h30, 32'hFF00_FF00, 32'hF0F0_F0F0, 0, 1, 0, 1'b1, 32'h0FF0_0FF0, 5);
        run_amo("and", OP_AND, 32'h34, 32'hFF00_FF00, 32'hF0F0_F0F0, 1, 0, 1, 1'b1, 32'hF000_F000, 5);
        run_amo("or_zero", OP_OR, 32'h38, 32'h0, 32'h1234_0000, 0, 0, 0, !skip_en, 32'h1234_0000, skip_en ? 3 : 4);
        run_amo("max_s", OP_MAX, 32'h3C, 32'd5, 32'h8000_0000, 0, 0, 0, 1'b1, 32'd5, 4);
        run_amo("max_u", OP_MAXU, 32'h40, 32'd5, 32'h8000_0000, 0, 0, 0, !skip_en, 32'h8000_0000, skip_en ? 3 : 4);
        run_amo("max_tie", OP_MAX, 32'h44, 32'd7, 32'd7, 0, 0, 0, !skip_en, 32'd7, skip_en ? 3 : 4);
        run_amo("min_neg", OP_MIN, 32'h48, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, 1'b1, 32'hFFFF_FFFE, 4);

        // Non-atomic request is swallowed in IDLE.
        @(negedge clk);
        v_i = 1'b1; decode_i = '0; decode_i.ld_op = 1'b1; addr_i = 32'h50; data_i = 32'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) begin v_i = 1'b0; decode_i = '0; end
            check("lw_ready", 32'(ready_o), 32'd1);
            check("lw_no_mem", 32'(mem_v_o), 32'd0);
        end

        // Reset while the write is pending.
        v_i = 1'b1; decode_i = mk_amo(OP_ADD); addr_i = 32'h60; data_i = 32'd5;
        @(negedge clk);
        v_i = 1'b0; decode_i = '0;
        check("abort_rd", 32'({mem_v_o, mem_w_o}), 32'b10);
        mem_yumi_i = 1'b1;
        @(negedge clk);
        mem_yumi_i = 1'b0; mem_data_v_i = 1'b1; mem_data_i = 32'd10;
        @(negedge clk);
        mem_data_v_i = 1'b0;
        check("abort_wr", 32'({mem_v_o, mem_w_o}), 32'b11);
        check("abort_wdata", mem_data_o, 32'd15);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check("abort_mem_v", 32'(mem_v_o), 32'd0);
        check("abort_ready", 32'(ready_o), 32'd1);
        check("abort_v_o", 32'(v_o), 32'd0);
        mem_data_v_i = 1'b1; mem_data_i = 32'h0BAD_0BAD;
        @(negedge clk);
        mem_data_v_i = 1'b0;
        check("stray_mem_v", 32'(mem_v_o), 32'd0);
        check("stray_v_o", 32'(v_o), 32'd0);
        check("stray_ready", 32'(ready_o), 32'd1);
        run_amo("swap_103", OP_SWAP, 32'h103, 32'hA5A5_A5A5, 32'h1111_1111, 0, 0, 0, 1'b1, 32'hA5A5_A5A5, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
